// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the N-way write-back cache.
// Field widths are derived from the instantiating module's parameters.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    REFILL,
    WTHRU,
    RESPOND
  } state_t;

  function automatic int tag_width(int adr_w, int idx_w, int wo);
    return adr_w - idx_w - wo;
  endfunction

  function automatic int line_words(int wo);
    return 1 << wo;
  endfunction

  function automatic int age_width(int ways);
    return $clog2(ways);
  endfunction

  function automatic logic [63:0] adr_word(logic [63:0] adr, int wo);
    return adr & ((64'd1 << wo) - 64'd1);
  endfunction

  function automatic logic [63:0] adr_index(logic [63:0] adr, int wo, int idx_w);
    return (adr >> wo) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] adr_tag(logic [63:0] adr, int wo, int idx_w);
    return adr >> (wo + idx_w);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim pick for one set (purely combinational).
// Age 0 is most recently used; age WAYS-1 is the eviction candidate.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int AGE_WIDTH = age_width(WAYS)
) (
  input  logic [WAYS-1:0][AGE_WIDTH-1:0] ages_i,
  input  logic [AGE_WIDTH-1:0]           acc_way_i,
  output logic [WAYS-1:0][AGE_WIDTH-1:0] ages_o,
  output logic [AGE_WIDTH-1:0]           victim_o
);

  logic [AGE_WIDTH-1:0] acc_age;

  always_comb begin
    ages_o   = ages_i;
    victim_o = '0;
    acc_age  = ages_i[acc_way_i];
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_WIDTH'(w) == acc_way_i)
        ages_o[w] = '0;
      else if (ages_i[w] < acc_age)
        ages_o[w] = ages_i[w] + AGE_WIDTH'(1);
      if (ages_i[w] == AGE_WIDTH'(WAYS - 1))
        victim_o = AGE_WIDTH'(w);
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back cache controller with true-LRU replacement
// and a word-serial memory port; write misses either allocate or write through.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int ADR_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_OFFSET    = 2,
  parameter int INDEX_WIDTH    = 4,
  parameter int WAYS           = 4,
  parameter int WRITE_ALLOCATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_i,
  input  logic [ADR_WIDTH-1:0]  cpu_adr_i,
  input  logic [DATA_WIDTH-1:0] cpu_dat_i,
  input  logic                  cpu_rdwr_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] cpu_dat_o,
  output logic                  mem_req_o,
  output logic [ADR_WIDTH-1:0]  mem_adr_o,
  output logic                  mem_rdwr_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_dat_i
);

  localparam int TAG_WIDTH  = tag_width(ADR_WIDTH, INDEX_WIDTH, WORD_OFFSET);
  localparam int LINE_WORDS = line_words(WORD_OFFSET);
  localparam int AGE_WIDTH  = age_width(WAYS);
  localparam int SETS       = 1 << INDEX_WIDTH;

  state_t state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADR_WIDTH-1:0]   req_adr_q;
  logic [DATA_WIDTH-1:0]  req_dat_q;
  logic                   req_wr_q;
  logic [WORD_OFFSET-1:0] cnt_q;
  logic [AGE_WIDTH-1:0]   victim_q;

  logic [TAG_WIDTH-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][LINE_WORDS];
  logic [SETS-1:0]       valid_q  [WAYS];
  logic [SETS-1:0]       dirty_q  [WAYS];
  logic [WAYS-1:0][AGE_WIDTH-1:0] age_q [SETS];
  logic [WAYS-1:0][AGE_WIDTH-1:0] age_upd;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [WORD_OFFSET-1:0] req_word;
  logic                   hit, inv_found, last_word, mem_fire;
  logic [AGE_WIDTH-1:0]   hit_way, inv_way, lru_victim, victim_sel;

  assign req_tag   = TAG_WIDTH'(adr_tag(64'(req_adr_q), WORD_OFFSET, INDEX_WIDTH));
  assign req_idx   = INDEX_WIDTH'(adr_index(64'(req_adr_q), WORD_OFFSET, INDEX_WIDTH));
  assign req_word  = WORD_OFFSET'(adr_word(64'(req_adr_q), WORD_OFFSET));
  assign last_word = (cnt_q == WORD_OFFSET'(LINE_WORDS - 1));
  // Acks arriving while no request is outstanding are ignored.
  assign mem_fire  = mem_req_q & mem_ack_i;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_WIDTH'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = AGE_WIDTH'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS), .AGE_WIDTH(AGE_WIDTH)) u_lru (
    .ages_i   (age_q[req_idx]),
    .acc_way_i(hit_way),
    .ages_o   (age_upd),
    .victim_o (lru_victim)
  );

  assign victim_sel = inv_found ? inv_way : lru_victim;

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    case (state_q)
      IDLE:    if (cpu_req_i) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          state_d = RESPOND;
        end else if (req_wr_q && WRITE_ALLOCATE == 0) begin
          state_d   = WTHRU;
          mem_req_d = 1'b1;
        end else begin
          state_d   = dirty_q[victim_sel][req_idx] ? WBACK : REFILL;
          mem_req_d = 1'b1;
        end
      end
      WBACK: begin
        if (mem_fire && last_word) begin
          state_d   = REFILL;
          mem_req_d = 1'b0;
        end
      end
      REFILL: begin
        // Entered from WBACK with the request low: raise it after a one-cycle gap.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_fire && last_word) begin
          state_d   = LOOKUP;
          mem_req_d = 1'b0;
        end
      end
      WTHRU: begin
        if (mem_fire) begin
          state_d   = RESPOND;
          mem_req_d = 1'b0;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      cnt_q     <= '0;
      victim_q  <= '0;
      req_adr_q <= '0;
      req_dat_q <= '0;
      req_wr_q  <= 1'b0;
      cpu_dat_o <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_WIDTH'(w);
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            req_adr_q <= cpu_adr_i;
            req_dat_q <= cpu_dat_i;
            req_wr_q  <= cpu_rdwr_i;
          end
        end
        LOOKUP: begin
          cnt_q <= '0;
          if (hit) begin
            age_q[req_idx] <= age_upd;
            if (req_wr_q) dirty_q[hit_way][req_idx] <= 1'b1;
            else          cpu_dat_o <= data_mem[hit_way][req_idx][req_word];
          end else begin
            victim_q <= victim_sel;
          end
        end
        WBACK: begin
          if (mem_fire) begin
            cnt_q <= cnt_q + WORD_OFFSET'(1);
            if (last_word) dirty_q[victim_q][req_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_fire) begin
            cnt_q <= cnt_q + WORD_OFFSET'(1);
            if (last_word) begin
              valid_q[victim_q][req_idx] <= 1'b1;
              dirty_q[victim_q][req_idx] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && hit && req_wr_q)
      data_mem[hit_way][req_idx][req_word] <= req_dat_q;
    if (state_q == REFILL && mem_fire) begin
      data_mem[victim_q][req_idx][cnt_q] <= mem_dat_i;
      if (last_word) tag_mem[victim_q][req_idx] <= req_tag;
    end
  end

  assign cpu_ack_o = (state_q == RESPOND);
  assign mem_req_o = mem_req_q;

  always_comb begin
    mem_adr_o  = '0;
    mem_dat_o  = '0;
    mem_rdwr_o = 1'b0;
    if (mem_req_q) begin
      case (state_q)
        WBACK: begin
          mem_adr_o  = {tag_mem[victim_q][req_idx], req_idx, cnt_q};
          mem_dat_o  = data_mem[victim_q][req_idx][cnt_q];
          mem_rdwr_o = 1'b1;
        end
        REFILL: mem_adr_o = {req_tag, req_idx, cnt_q};
        WTHRU: begin
          mem_adr_o  = req_adr_q;
          mem_dat_o  = req_dat_q;
          mem_rdwr_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: one write-allocate instance for most
// scenarios and one write-no-allocate instance for the write-through miss.
module tb_cache_nway_wb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req = 0, a_rdwr = 0, a_ack, a_mreq, a_mrdwr, a_mack = 0;
  logic [31:0] a_adr = 0, a_dat = 0, a_dout, a_madr, a_mdat, a_mdin = 0;
  logic        b_req = 0, b_rdwr = 0, b_ack, b_mreq, b_mrdwr, b_mack = 0;
  logic [31:0] b_adr = 0, b_dat = 0, b_dout, b_madr, b_mdat, b_mdin = 0;

  cache_nway_wb dut_a (
    .clk(clk), .rst(rst_n),
    .cpu_req_i(a_req), .cpu_adr_i(a_adr), .cpu_dat_i(a_dat), .cpu_rdwr_i(a_rdwr),
    .cpu_ack_o(a_ack), .cpu_dat_o(a_dout),
    .mem_req_o(a_mreq), .mem_adr_o(a_madr), .mem_rdwr_o(a_mrdwr), .mem_dat_o(a_mdat),
    .mem_ack_i(a_mack), .mem_dat_i(a_mdin)
  );

  cache_nway_wb #(.WRITE_ALLOCATE(0)) dut_b (
    .clk(clk), .rst(rst_n),
    .cpu_req_i(b_req), .cpu_adr_i(b_adr), .cpu_dat_i(b_dat), .cpu_rdwr_i(b_rdwr),
    .cpu_ack_o(b_ack), .cpu_dat_o(b_dout),
    .mem_req_o(b_mreq), .mem_adr_o(b_madr), .mem_rdwr_o(b_mrdwr), .mem_dat_o(b_mdat),
    .mem_ack_i(b_mack), .mem_dat_i(b_mdin)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_words [4];
  logic [31:0] cap_adr  [4];
  logic [31:0] cap_dat  [4];
  logic        cap_wr   [4];
  logic        burst_to;
  logic        ack_got, saw_mreq;
  int          ack_cycles;
  logic [31:0] ack_dat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic a_cpu(input logic [31:0] adr, input logic wr, input logic [31:0] d);
    a_req = 1'b1; a_adr = adr; a_rdwr = wr; a_dat = d;
  endtask

  // Serves n memory words on instance A, recording what the DUT presented.
  task automatic a_burst(input int n);
    burst_to = 1'b0;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (a_mreq !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) burst_to = 1'b1;
      cap_adr[i] = a_madr; cap_dat[i] = a_mdat; cap_wr[i] = a_mrdwr;
      a_mack = 1'b1; a_mdin = rd_words[i];
      @(negedge clk);
      a_mack = 1'b0;
    end
  endtask

  task automatic a_wait_ack();
    ack_got = 1'b0; ack_cycles = 0; saw_mreq = 1'b0; ack_dat = '0;
    while (!ack_got && ack_cycles < 40) begin
      @(negedge clk);
      ack_cycles++;
      if (a_mreq === 1'b1) saw_mreq = 1'b1;
      if (a_ack === 1'b1) begin ack_got = 1'b1; ack_dat = a_dout; end
    end
  endtask

  task automatic a_read_fill(input logic [31:0] adr, input logic [31:0] base);
    for (int i = 0; i < 4; i++) rd_words[i] = base + i;
    a_cpu(adr, 1'b0, '0);
    a_burst(4);
    a_wait_ack();
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", a_ack); end
    checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", a_dout); end
    checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL rst_mreq got=%b exp=0", a_mreq); end
    checks++; if (a_madr !== 32'h0 || a_mdat !== 32'h0 || a_mrdwr !== 1'b0) begin
      errors++; $display("FAIL rst_mem_out got adr=%h dat=%h rdwr=%b exp all 0", a_madr, a_mdat, a_mrdwr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_ack !== 1'b0 || a_mreq !== 1'b0) begin
      errors++; $display("FAIL rst_release got ack=%b mreq=%b exp 0 0", a_ack, a_mreq); end
  endtask

  task automatic test_cold_miss_then_hit();
    for (int i = 0; i < 4; i++) rd_words[i] = 32'hA0 + i;
    a_cpu(32'h123, 1'b0, '0);
    a_burst(4);
    checks++; if (burst_to !== 1'b0) begin errors++; $display("FAIL t1_burst_timeout got=%b exp=0", burst_to); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_adr[i] !== 32'h120 + i || cap_wr[i] !== 1'b0) begin
        errors++; $display("FAIL t1_refill_adr[%0d] got adr=%h rdwr=%b exp adr=%h rdwr=0", i, cap_adr[i], cap_wr[i], 32'h120 + i); end
    end
    checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL t1_mreq_after_last got=%b exp=0", a_mreq); end
    a_wait_ack();
    checks++; if (ack_got !== 1'b1 || ack_dat !== 32'hA3) begin
      errors++; $display("FAIL t1_miss_rdata got ack=%b dat=%h exp ack=1 dat=000000a3", ack_got, ack_dat); end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL t1_ack_pulse got=%b exp=0", a_ack); end
    a_cpu(32'h121, 1'b0, '0);
    a_wait_ack();
    checks++; if (ack_cycles != 2) begin errors++; $display("FAIL t1_hit_latency got=%0d exp=2", ack_cycles); end
    checks++; if (ack_dat !== 32'hA1) begin errors++; $display("FAIL t1_hit_rdata got=%h exp=000000a1", ack_dat); end
    checks++; if (saw_mreq !== 1'b0) begin errors++; $display("FAIL t1_hit_mem_traffic got=%b exp=0", saw_mreq); end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_hit();
    a_cpu(32'h122, 1'b1, 32'hDEADBEEF);
    a_wait_ack();
    checks++; if (ack_got !== 1'b1 || ack_cycles != 2) begin
      errors++; $display("FAIL t2_write_ack got ack=%b cycles=%0d exp ack=1 cycles=2", ack_got, ack_cycles); end
    checks++; if (saw_mreq !== 1'b0) begin errors++; $display("FAIL t2_write_mem_traffic got=%b exp=0", saw_mreq); end
    a_req = 1'b0;
    @(negedge clk);
    a_cpu(32'h122, 1'b0, '0);
    a_wait_ack();
    checks++; if (ack_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_readback got=%h exp=deadbeef", ack_dat); end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dirty_eviction();
    a_read_fill(32'h163, 32'hB0);
    checks++; if (ack_dat !== 32'hB3) begin errors++; $display("FAIL t3_fill1 got=%h exp=000000b3", ack_dat); end
    a_read_fill(32'h1A3, 32'hC0);
    checks++; if (ack_dat !== 32'hC3) begin errors++; $display("FAIL t3_fill2 got=%h exp=000000c3", ack_dat); end
    a_read_fill(32'h1E3, 32'hD0);
    checks++; if (ack_dat !== 32'hD3) begin errors++; $display("FAIL t3_fill3 got=%h exp=000000d3", ack_dat); end
    for (int i = 0; i < 4; i++) rd_words[i] = 32'h0;
    a_cpu(32'h223, 1'b0, '0);
    a_burst(4);
    checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL t3_wb_refill_gap got=%b exp=0", a_mreq); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_d;
      exp_d = (i == 2) ? 32'hDEADBEEF : 32'hA0 + i;
      checks++;
      if (cap_adr[i] !== 32'h120 + i || cap_wr[i] !== 1'b1 || cap_dat[i] !== exp_d) begin
        errors++; $display("FAIL t3_wback[%0d] got adr=%h rdwr=%b dat=%h exp adr=%h rdwr=1 dat=%h",
                           i, cap_adr[i], cap_wr[i], cap_dat[i], 32'h120 + i, exp_d); end
    end
    for (int i = 0; i < 4; i++) rd_words[i] = 32'hE0 + i;
    a_burst(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_adr[i] !== 32'h220 + i || cap_wr[i] !== 1'b0) begin
        errors++; $display("FAIL t3_refill[%0d] got adr=%h rdwr=%b exp adr=%h rdwr=0", i, cap_adr[i], cap_wr[i], 32'h220 + i); end
    end
    a_wait_ack();
    checks++; if (ack_dat !== 32'hE3) begin errors++; $display("FAIL t3_evict_rdata got=%h exp=000000e3", ack_dat); end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_no_allocate();
    int t;
    b_req = 1'b1; b_adr = 32'h300; b_rdwr = 1'b1; b_dat = 32'h1234;
    t = 0;
    while (b_mreq !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++; if (b_madr !== 32'h300 || b_mrdwr !== 1'b1 || b_mdat !== 32'h1234) begin
      errors++; $display("FAIL t4_wthru got adr=%h rdwr=%b dat=%h exp adr=300 rdwr=1 dat=1234", b_madr, b_mrdwr, b_mdat); end
    b_mack = 1'b1;
    @(negedge clk);
    b_mack = 1'b0;
    checks++; if (b_mreq !== 1'b0) begin errors++; $display("FAIL t4_mreq_after_ack got=%b exp=0", b_mreq); end
    t = 0;
    while (b_ack !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL t4_write_ack got=%b exp=1", b_ack); end
    b_req = 1'b0;
    @(negedge clk);
    b_req = 1'b1; b_rdwr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (b_mreq !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (b_madr !== 32'h300 + i || b_mrdwr !== 1'b0) begin
        errors++; $display("FAIL t4_read_refill[%0d] got adr=%h rdwr=%b mreq=%b exp adr=%h rdwr=0", i, b_madr, b_mrdwr, b_mreq, 32'h300 + i); end
      b_mack = 1'b1; b_mdin = 32'hF0 + i;
      @(negedge clk);
      b_mack = 1'b0;
    end
    t = 0;
    while (b_ack !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++; if (b_ack !== 1'b1 || b_dout !== 32'hF0) begin
      errors++; $display("FAIL t4_read_rdata got ack=%b dat=%h exp ack=1 dat=000000f0", b_ack, b_dout); end
    b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_refill();
    for (int i = 0; i < 4; i++) rd_words[i] = 32'h50 + i;
    a_cpu(32'h123, 1'b0, '0);
    a_burst(2);
    checks++; if (a_mreq !== 1'b1) begin errors++; $display("FAIL t5_mid_burst_mreq got=%b exp=1", a_mreq); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_mreq !== 1'b0 || a_ack !== 1'b0 || a_madr !== 32'h0) begin
      errors++; $display("FAIL t5_async_reset got mreq=%b ack=%b adr=%h exp 0 0 0", a_mreq, a_ack, a_madr); end
    a_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) rd_words[i] = 32'h60 + i;
    a_cpu(32'h123, 1'b0, '0);
    a_burst(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_adr[i] !== 32'h120 + i || cap_wr[i] !== 1'b0) begin
        errors++; $display("FAIL t5_rerefill[%0d] got adr=%h rdwr=%b exp adr=%h rdwr=0", i, cap_adr[i], cap_wr[i], 32'h120 + i); end
    end
    a_wait_ack();
    checks++; if (ack_dat !== 32'h63) begin errors++; $display("FAIL t5_rdata got=%h exp=00000063", ack_dat); end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    a_mack = 1'b1; a_mdin = 32'hFFFF_FFFF;
    @(negedge clk);
    a_mack = 1'b0;
    @(negedge clk);
    checks++; if (a_mreq !== 1'b0 || a_ack !== 1'b0) begin
      errors++; $display("FAIL t6_stray_ack got mreq=%b ack=%b exp 0 0", a_mreq, a_ack); end
    a_cpu(32'h121, 1'b0, '0);
    a_wait_ack();
    checks++; if (ack_dat !== 32'h61 || ack_cycles != 2 || saw_mreq !== 1'b0) begin
      errors++; $display("FAIL t6_hit_after_stray got dat=%h cycles=%0d mreq=%b exp 61 2 0", ack_dat, ack_cycles, saw_mreq); end
    a_cpu(32'h122, 1'b0, '0);
    a_wait_ack();
    checks++; if (ack_got !== 1'b1 || ack_dat !== 32'h62 || ack_cycles != 3) begin
      errors++; $display("FAIL t6_b2b_read got ack=%b dat=%h cycles=%0d exp 1 62 3", ack_got, ack_dat, ack_cycles); end
    a_cpu(32'h120, 1'b1, 32'h5A5A_0001);
    a_wait_ack();
    checks++; if (ack_got !== 1'b1 || ack_cycles != 3 || saw_mreq !== 1'b0) begin
      errors++; $display("FAIL t6_b2b_write got ack=%b cycles=%0d mreq=%b exp 1 3 0", ack_got, ack_cycles, saw_mreq); end
    a_cpu(32'h120, 1'b0, '0);
    a_wait_ack();
    checks++; if (ack_dat !== 32'h5A5A_0001) begin errors++; $display("FAIL t6_b2b_readback got=%h exp=5a5a0001", ack_dat); end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cold_miss_then_hit();
    test_write_hit();
    test_dirty_eviction();
    test_write_no_allocate();
    test_reset_mid_refill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
